// File: rtl/vp_fp16_mask_mul_if.sv
// ----------------------------------------------------------------------------
// vp_fp16_mask_mul_if
// Handshake and data bundle for the masked FP16 multiplier core.
//
// Signals:
//   in_valid  producer -> core   operand/mask beat valid
//   in_ready  core -> producer   core can accept a beat this cycle
//   a_i, b_i  producer -> core   FP16 operands
//   mask_i    producer -> core   significand mask, MSB aligned with hidden bit
//   out_valid core -> consumer   product valid
//   out_ready consumer -> core   consumer accepts the product
//   p_o       core -> consumer   FP16 product
//
// Modports:
//   master : the environment side (drives operands, accepts products)
//   slave  : the multiplier core
// ----------------------------------------------------------------------------
interface vp_fp16_mask_mul_if #(
   parameter int EXP_W = 5,
   parameter int MAN_W = 10
);
   logic                   in_valid;
   logic                   in_ready;
   logic [EXP_W+MAN_W:0]   a_i;
   logic [EXP_W+MAN_W:0]   b_i;
   logic [MAN_W:0]         mask_i;
   logic                   out_valid;
   logic                   out_ready;
   logic [EXP_W+MAN_W:0]   p_o;

   modport master (
      output in_valid,
      output a_i,
      output b_i,
      output mask_i,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  p_o
   );

   modport slave (
      input  in_valid,
      input  a_i,
      input  b_i,
      input  mask_i,
      input  out_ready,
      output in_ready,
      output out_valid,
      output p_o
   );
endinterface

// File: rtl/vp_fp16_mask_mul.sv
// ----------------------------------------------------------------------------
// vp_fp16_mask_mul
// Pipelined approximate FP16 multiplier. Both operand significands are
// AND-ed with the precision mask (hidden bit always kept), multiplied,
// normalized by truncation and packed back to FP16. Subnormal inputs are
// flushed to zero, overflow saturates to infinity, underflow flushes to zero.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset; clears every stage valid and p_o
//   bus  vp_fp16_mask_mul_if.slave: in_valid/in_ready/a_i/b_i/mask_i on the
//        input side, out_valid/out_ready/p_o on the output side
//
// Pipeline (one global enable adv = !out_valid | out_ready, in_ready = adv):
//   stage 0 : capture a, b and mask on acceptance
//   stage 1 : unpack, mask significands, exponent sum, special-case class
//   stage 2 : 11x11 significand product (only the bits kept by truncation)
//   stage 3 : normalize, apply special/range priority, pack -> p_o
// A beat accepted at edge N is presented with out_valid=1 after edge N+3.
// ----------------------------------------------------------------------------
module vp_fp16_mask_mul #(
   parameter int EXP_W = 5,
   parameter int MAN_W = 10,
   parameter int BIAS  = 15
) (
   input  logic              clk,
   input  logic              rst,
   vp_fp16_mask_mul_if.slave bus
);

   localparam int W     = 1 + EXP_W + MAN_W;   // packed FP width
   localparam int SIG_W = MAN_W + 1;           // significand incl. hidden bit
   localparam int HI_W  = SIG_W + 1;           // product bits above the truncation point
   localparam int ES_W  = EXP_W + 2;           // signed exponent-sum width

   localparam logic [ES_W-1:0] BIAS_ES = ES_W'(BIAS);
   localparam logic [ES_W-1:0] EMAX_ES = ES_W'((1 << EXP_W) - 1);
   localparam logic [ES_W-1:0] ONE_ES  = ES_W'(1);

   // Operand / result classes. NAN also covers inf x zero.
   localparam logic [1:0] CLS_NORM = 2'd0;
   localparam logic [1:0] CLS_NAN  = 2'd1;
   localparam logic [1:0] CLS_INF  = 2'd2;
   localparam logic [1:0] CLS_ZERO = 2'd3;

   // ------------------------------------------------------------------------
   // Helper functions
   // ------------------------------------------------------------------------

   // Classify one FP operand; a zero exponent (zero or subnormal) is zero.
   function automatic logic [1:0] op_class(input logic [W-1:0] x);
      logic [EXP_W-1:0] e;
      logic [MAN_W-1:0] m;
      logic [1:0]       c;
      e = x[W-2:MAN_W];
      m = x[MAN_W-1:0];
      if (e == {EXP_W{1'b0}}) begin
         c = CLS_ZERO;
      end else if (e == {EXP_W{1'b1}}) begin
         if (m == {MAN_W{1'b0}}) begin
            c = CLS_INF;
         end else begin
            c = CLS_NAN;
         end
      end else begin
         c = CLS_NORM;
      end
      return c;
   endfunction

   // Combine operand classes into the class of the product, highest priority first.
   function automatic logic [1:0] prod_class(input logic [1:0] ca, input logic [1:0] cb);
      logic [1:0] c;
      if ((ca == CLS_NAN) || (cb == CLS_NAN)) begin
         c = CLS_NAN;
      end else if (((ca == CLS_INF) && (cb == CLS_ZERO)) ||
                   ((ca == CLS_ZERO) && (cb == CLS_INF))) begin
         c = CLS_NAN;
      end else if ((ca == CLS_INF) || (cb == CLS_INF)) begin
         c = CLS_INF;
      end else if ((ca == CLS_ZERO) || (cb == CLS_ZERO)) begin
         c = CLS_ZERO;
      end else begin
         c = CLS_NORM;
      end
      return c;
   endfunction

   // Build the final word; finite results saturate/flush on the biased exponent.
   function automatic logic [W-1:0] pack_result(
      input logic            sign,
      input logic [1:0]      cls,
      input logic [ES_W-1:0] e,
      input logic [MAN_W-1:0] man
   );
      logic [W-1:0] r;
      case (cls)
         CLS_NAN:  r = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
         CLS_INF:  r = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         CLS_ZERO: r = {sign, {(W-1){1'b0}}};
         default: begin
            if ($signed(e) >= $signed(EMAX_ES)) begin
               r = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            end else if ($signed(e) < $signed(ONE_ES)) begin
               r = {sign, {(W-1){1'b0}}};
            end else begin
               r = {sign, e[EXP_W-1:0], man};
            end
         end
      endcase
      return r;
   endfunction

   // ------------------------------------------------------------------------
   // Pipeline state
   // ------------------------------------------------------------------------
   logic                adv_s;

   logic                v0_q, v0_d;
   logic                v1_q, v1_d;
   logic                v2_q, v2_d;
   logic                v3_q, v3_d;

   logic [W-1:0]        a0_q, a0_d;
   logic [W-1:0]        b0_q, b0_d;
   logic [SIG_W-1:0]    m0_q, m0_d;

   logic                sign1_q, sign1_d;
   logic [1:0]          cls1_q, cls1_d;
   logic [ES_W-1:0]     es1_q, es1_d;
   logic [SIG_W-1:0]    sa1_q, sa1_d;
   logic [SIG_W-1:0]    sb1_q, sb1_d;

   logic                sign2_q, sign2_d;
   logic [1:0]          cls2_q, cls2_d;
   logic [ES_W-1:0]     es2_q, es2_d;
   logic [HI_W-1:0]     prod2_q, prod2_d;

   logic [ES_W-1:0]     e3_s;
   logic [MAN_W-1:0]    man3_s;
   logic [W-1:0]        p3_q, p3_d;

   assign bus.in_ready  = adv_s;
   assign bus.out_valid = v3_q;
   assign bus.p_o       = p3_q;

   // Global advance and valid chain; a stall freezes bubbles as well as beats.
   always_comb begin
      adv_s = (!v3_q) | bus.out_ready;
      v0_d  = v0_q;
      v1_d  = v1_q;
      v2_d  = v2_q;
      v3_d  = v3_q;
      if (adv_s) begin
         v0_d = bus.in_valid;
         v1_d = v0_q;
         v2_d = v1_q;
         v3_d = v2_q;
      end else begin
         v0_d = v0_q;
         v1_d = v1_q;
         v2_d = v2_q;
         v3_d = v3_q;
      end
   end

   // Stage 0: capture operands and mask; the hidden-bit position is forced to 1.
   always_comb begin
      a0_d = a0_q;
      b0_d = b0_q;
      m0_d = m0_q;
      if (adv_s && bus.in_valid) begin
         a0_d = bus.a_i;
         b0_d = bus.b_i;
         m0_d = bus.mask_i | {1'b1, {MAN_W{1'b0}}};
      end else begin
         a0_d = a0_q;
         b0_d = b0_q;
         m0_d = m0_q;
      end
   end

   // Stage 1: sign, masked significands, biased exponent sum and class.
   always_comb begin
      sign1_d = sign1_q;
      cls1_d  = cls1_q;
      es1_d   = es1_q;
      sa1_d   = sa1_q;
      sb1_d   = sb1_q;
      if (adv_s) begin
         sign1_d = a0_q[W-1] ^ b0_q[W-1];
         cls1_d  = prod_class(op_class(a0_q), op_class(b0_q));
         // Two's-complement wrap makes es a signed value in ES_W bits.
         es1_d   = {{(ES_W-EXP_W){1'b0}}, a0_q[W-2:MAN_W]}
                 + {{(ES_W-EXP_W){1'b0}}, b0_q[W-2:MAN_W]}
                 - BIAS_ES;
         sa1_d   = {1'b1, a0_q[MAN_W-1:0]} & m0_q;
         sb1_d   = {1'b1, b0_q[MAN_W-1:0]} & m0_q;
      end else begin
         sign1_d = sign1_q;
         cls1_d  = cls1_q;
         es1_d   = es1_q;
         sa1_d   = sa1_q;
         sb1_d   = sb1_q;
      end
   end

   // Stage 2: significand product; bits below the truncation point are never used.
   always_comb begin
      sign2_d = sign2_q;
      cls2_d  = cls2_q;
      es2_d   = es2_q;
      prod2_d = prod2_q;
      if (adv_s) begin
         sign2_d = sign1_q;
         cls2_d  = cls1_q;
         es2_d   = es1_q;
         prod2_d = HI_W'(({{SIG_W{1'b0}}, sa1_q} * {{SIG_W{1'b0}}, sb1_q}) >> MAN_W);
      end else begin
         sign2_d = sign2_q;
         cls2_d  = cls2_q;
         es2_d   = es2_q;
         prod2_d = prod2_q;
      end
   end

   // Stage 3 normalize: product in [1,4); a set top bit means shift by one more.
   always_comb begin
      e3_s   = es2_q;
      man3_s = prod2_q[MAN_W-1:0];
      if (prod2_q[HI_W-1]) begin
         e3_s   = es2_q + ONE_ES;
         man3_s = prod2_q[HI_W-2:1];
      end else begin
         e3_s   = es2_q;
         man3_s = prod2_q[MAN_W-1:0];
      end
   end

   // Stage 3 pack: p_o only changes when a real beat moves into the output slot.
   always_comb begin
      p3_d = p3_q;
      if (adv_s && v2_q) begin
         p3_d = pack_result(sign2_q, cls2_q, e3_s, man3_s);
      end else begin
         p3_d = p3_q;
      end
   end

   // State registers with synchronous reset; in-flight beats are discarded.
   always_ff @(posedge clk) begin
      if (rst) begin
         v0_q    <= 1'b0;
         v1_q    <= 1'b0;
         v2_q    <= 1'b0;
         v3_q    <= 1'b0;
         a0_q    <= {W{1'b0}};
         b0_q    <= {W{1'b0}};
         m0_q    <= {SIG_W{1'b0}};
         sign1_q <= 1'b0;
         cls1_q  <= CLS_NORM;
         es1_q   <= {ES_W{1'b0}};
         sa1_q   <= {SIG_W{1'b0}};
         sb1_q   <= {SIG_W{1'b0}};
         sign2_q <= 1'b0;
         cls2_q  <= CLS_NORM;
         es2_q   <= {ES_W{1'b0}};
         prod2_q <= {HI_W{1'b0}};
         p3_q    <= {W{1'b0}};
      end else begin
         v0_q    <= v0_d;
         v1_q    <= v1_d;
         v2_q    <= v2_d;
         v3_q    <= v3_d;
         a0_q    <= a0_d;
         b0_q    <= b0_d;
         m0_q    <= m0_d;
         sign1_q <= sign1_d;
         cls1_q  <= cls1_d;
         es1_q   <= es1_d;
         sa1_q   <= sa1_d;
         sb1_q   <= sb1_d;
         sign2_q <= sign2_d;
         cls2_q  <= cls2_d;
         es2_q   <= es2_d;
         prod2_q <= prod2_d;
         p3_q    <= p3_d;
      end
   end

endmodule

// File: tb/tb_vp_fp16_mask_mul.sv
// ----------------------------------------------------------------------------
// tb_vp_fp16_mask_mul
// Directed and random checks of vp_fp16_mask_mul. Inputs are driven on the
// falling edge and outputs are sampled 1 time unit later, so every handshake
// decision is taken from stable values before the next rising edge.
// ----------------------------------------------------------------------------
module tb_vp_fp16_mask_mul;

   localparam int NDIR = 13;

   logic clk;
   logic rst;

   vp_fp16_mask_mul_if bus ();

   vp_fp16_mask_mul dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total;
   int bad;

   logic [15:0] dir_a [NDIR];
   logic [15:0] dir_b [NDIR];
   logic [10:0] dir_m [NDIR];
   logic [15:0] dir_p [NDIR];

   logic        obs_acc;
   logic        obs_pop;
   logic        obs_ov;
   logic        obs_ir;
   logic [15:0] obs_p;

   // Reference: masks, multiplies, truncates and saturates with integer math.
   function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                           input logic [10:0] m);
      int  ea, eb, ma, mb, sa, sb, p, e, man;
      logic s, nan_a, nan_b, inf_a, inf_b, zer_a, zer_b;
      s  = a[15] ^ b[15];
      ea = a[14:10];
      eb = b[14:10];
      ma = a[9:0];
      mb = b[9:0];
      nan_a = (ea == 31) && (ma != 0);
      nan_b = (eb == 31) && (mb != 0);
      inf_a = (ea == 31) && (ma == 0);
      inf_b = (eb == 31) && (mb == 0);
      zer_a = (ea == 0);
      zer_b = (eb == 0);
      if (nan_a || nan_b || (inf_a && zer_b) || (inf_b && zer_a)) return 16'h7E00;
      if (inf_a || inf_b) return {s, 5'h1F, 10'h000};
      if (zer_a || zer_b) return {s, 15'h0000};
      sa = 1024 + (ma & int'(m[9:0]));
      sb = 1024 + (mb & int'(m[9:0]));
      p  = sa * sb;
      if (p >= (1 << 21)) begin
         man = (p >> 11) % 1024;
         e   = ea + eb - 14;
      end else begin
         man = (p >> 10) % 1024;
         e   = ea + eb - 15;
      end
      if (e >= 31) return {s, 5'h1F, 10'h000};
      if (e <= 0) return {s, 15'h0000};
      return {s, 5'(e), 10'(man)};
   endfunction

   // Drive one cycle of inputs at the falling edge, then sample the outputs.
   task automatic cycle(input logic v, input logic [15:0] a, input logic [15:0] b,
                        input logic [10:0] m, input logic ordy);
      @(negedge clk);
      bus.in_valid  = v;
      bus.a_i       = a;
      bus.b_i       = b;
      bus.mask_i    = m;
      bus.out_ready = ordy;
      #1;
      obs_ir  = bus.in_ready;
      obs_ov  = bus.out_valid;
      obs_p   = bus.p_o;
      obs_acc = v & obs_ir;
      obs_pop = obs_ov & ordy;
   endtask

   task automatic init_tables();
      dir_a[0]  = 16'h3C00; dir_b[0]  = 16'h3C00; dir_m[0]  = 11'h7FF; dir_p[0]  = 16'h3C00;
      dir_a[1]  = 16'h3E00; dir_b[1]  = 16'h3E00; dir_m[1]  = 11'h7FF; dir_p[1]  = 16'h4080;
      dir_a[2]  = 16'h3E00; dir_b[2]  = 16'h3E00; dir_m[2]  = 11'h400; dir_p[2]  = 16'h3C00;
      dir_a[3]  = 16'h3E00; dir_b[3]  = 16'h3E00; dir_m[3]  = 11'h000; dir_p[3]  = 16'h3C00;
      dir_a[4]  = 16'h7BFF; dir_b[4]  = 16'h7BFF; dir_m[4]  = 11'h7FF; dir_p[4]  = 16'h7C00;
      dir_a[5]  = 16'h0400; dir_b[5]  = 16'h0400; dir_m[5]  = 11'h7FF; dir_p[5]  = 16'h0000;
      dir_a[6]  = 16'h7C00; dir_b[6]  = 16'h0000; dir_m[6]  = 11'h7FF; dir_p[6]  = 16'h7E00;
      dir_a[7]  = 16'hFC00; dir_b[7]  = 16'h3C00; dir_m[7]  = 11'h7FF; dir_p[7]  = 16'hFC00;
      dir_a[8]  = 16'h8000; dir_b[8]  = 16'h3C00; dir_m[8]  = 11'h7FF; dir_p[8]  = 16'h8000;
      dir_a[9]  = 16'h0001; dir_b[9]  = 16'h3C00; dir_m[9]  = 11'h7FF; dir_p[9]  = 16'h0000;
      dir_a[10] = 16'h4000; dir_b[10] = 16'hC200; dir_m[10] = 11'h7FF; dir_p[10] = 16'hC600;
      dir_a[11] = 16'h3FFF; dir_b[11] = 16'h3C00; dir_m[11] = 11'h700; dir_p[11] = 16'h3F00;
      dir_a[12] = 16'h7C01; dir_b[12] = 16'h3C00; dir_m[12] = 11'h7FF; dir_p[12] = 16'h7E00;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) cycle(1'b0, 16'h0000, 16'h0000, 11'h000, 1'b0);
      total++;
      if (obs_ov !== 1'b0) begin
         bad++; $display("FAIL reset_out_valid: got %b want 0", obs_ov);
      end
      total++;
      if (obs_p !== 16'h0000) begin
         bad++; $display("FAIL reset_p: got %h want 0000", obs_p);
      end
      total++;
      if (obs_ir !== 1'b1) begin
         bad++; $display("FAIL reset_in_ready: got %b want 1", obs_ir);
      end
      rst = 1'b0;
   endtask

   task automatic test_directed();
      for (int i = 0; i < NDIR; i++) begin
         int   lat;
         logic got;
         cycle(1'b1, dir_a[i], dir_b[i], dir_m[i], 1'b1);
         total++;
         if (obs_acc !== 1'b1) begin
            bad++; $display("FAIL dir_accept[%0d]: got %b want 1", i, obs_acc);
         end
         lat = 0;
         got = 1'b0;
         for (int k = 0; k < 10 && !got; k++) begin
            cycle(1'b0, 16'h0000, 16'h0000, 11'h000, 1'b1);
            if (obs_ov === 1'b1) got = 1'b1;
            else lat++;
         end
         total++;
         if (got !== 1'b1) begin
            bad++; $display("FAIL dir_timeout[%0d]: got no out_valid want out_valid", i);
         end
         total++;
         if (lat != 3) begin
            bad++; $display("FAIL dir_latency[%0d]: got %0d want 3", i, lat);
         end
         total++;
         if (obs_p !== dir_p[i]) begin
            bad++; $display("FAIL dir_p[%0d] %h*%h m=%h: got %h want %h",
                            i, dir_a[i], dir_b[i], dir_m[i], obs_p, dir_p[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] expq [$];
      logic [15:0] exp_p;
      int nin, nout, first_pop, last_pop, idx;
      nin = 0; nout = 0; first_pop = -1; last_pop = -1;
      for (int cyc = 0; cyc < 40 && nout < 6; cyc++) begin
         idx = (nin < 6) ? nin : 0;
         cycle(nin < 6, dir_a[idx], dir_b[idx], dir_m[idx], 1'b1);
         if (obs_pop) begin
            total++;
            if (expq.size() == 0) begin
               bad++; $display("FAIL b2b_extra: got %h want no result", obs_p);
            end else begin
               exp_p = expq.pop_front();
               if (obs_p !== exp_p) begin
                  bad++; $display("FAIL b2b_p[%0d]: got %h want %h", nout, obs_p, exp_p);
               end
            end
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
            nout++;
         end
         if (obs_acc) begin
            expq.push_back(dir_p[nin]);
            nin++;
         end
      end
      total++;
      if (nout != 6) begin
         bad++; $display("FAIL b2b_count: got %0d want 6", nout);
      end
      total++;
      if (last_pop - first_pop != 5) begin
         bad++; $display("FAIL b2b_consecutive: got span %0d want 5", last_pop - first_pop);
      end
   endtask

   task automatic test_stall();
      logic [15:0] expq [$];
      logic [15:0] exp_p;
      logic [15:0] held;
      logic        stall;
      int nin, nout, idx;
      nin = 0; nout = 0; held = 16'h0000;
      for (int cyc = 0; cyc < 80 && nout < NDIR; cyc++) begin
         stall = (cyc >= 5) && (cyc < 10);
         idx = (nin < NDIR) ? nin : 0;
         cycle(nin < NDIR, dir_a[idx], dir_b[idx], dir_m[idx], !stall);
         if (stall) begin
            if (cyc == 5) begin
               held = obs_p;
            end else begin
               total++;
               if (obs_p !== held) begin
                  bad++; $display("FAIL stall_p_stable[%0d]: got %h want %h", cyc, obs_p, held);
               end
            end
            total++;
            if (obs_ir !== 1'b0) begin
               bad++; $display("FAIL stall_in_ready[%0d]: got %b want 0", cyc, obs_ir);
            end
            total++;
            if (obs_ov !== 1'b1) begin
               bad++; $display("FAIL stall_out_valid[%0d]: got %b want 1", cyc, obs_ov);
            end
         end
         if (obs_pop) begin
            total++;
            if (expq.size() == 0) begin
               bad++; $display("FAIL stall_extra: got %h want no result", obs_p);
            end else begin
               exp_p = expq.pop_front();
               if (obs_p !== exp_p) begin
                  bad++; $display("FAIL stall_p[%0d]: got %h want %h", nout, obs_p, exp_p);
               end
            end
            nout++;
         end
         if (obs_acc) begin
            expq.push_back(dir_p[nin]);
            nin++;
         end
      end
      total++;
      if (nout != NDIR) begin
         bad++; $display("FAIL stall_count: got %0d want %0d", nout, NDIR);
      end
   endtask

   task automatic test_reset_inflight();
      int   stale, lat;
      logic got;
      for (int i = 0; i < 3; i++) cycle(1'b1, dir_a[i], dir_b[i], dir_m[i], 1'b1);
      rst = 1'b1;
      cycle(1'b0, 16'h0000, 16'h0000, 11'h000, 1'b1);
      rst = 1'b0;
      cycle(1'b0, 16'h0000, 16'h0000, 11'h000, 1'b1);
      total++;
      if (obs_ov !== 1'b0) begin
         bad++; $display("FAIL rstfl_out_valid: got %b want 0", obs_ov);
      end
      total++;
      if (obs_p !== 16'h0000) begin
         bad++; $display("FAIL rstfl_p: got %h want 0000", obs_p);
      end
      stale = 0;
      for (int k = 0; k < 8; k++) begin
         cycle(1'b0, 16'h0000, 16'h0000, 11'h000, 1'b1);
         if (obs_ov === 1'b1) stale++;
      end
      total++;
      if (stale != 0) begin
         bad++; $display("FAIL rstfl_stale: got %0d results want 0", stale);
      end
      cycle(1'b1, dir_a[1], dir_b[1], dir_m[1], 1'b1);
      total++;
      if (obs_acc !== 1'b1) begin
         bad++; $display("FAIL rstfl_accept: got %b want 1", obs_acc);
      end
      lat = 0;
      got = 1'b0;
      for (int k = 0; k < 10 && !got; k++) begin
         cycle(1'b0, 16'h0000, 16'h0000, 11'h000, 1'b1);
         if (obs_ov === 1'b1) got = 1'b1;
         else lat++;
      end
      total++;
      if (got !== 1'b1 || lat != 3) begin
         bad++; $display("FAIL rstfl_latency: got valid=%b lat=%0d want valid=1 lat=3", got, lat);
      end
      total++;
      if (obs_p !== 16'h4080) begin
         bad++; $display("FAIL rstfl_p_after: got %h want 4080", obs_p);
      end
      cycle(1'b0, 16'h0000, 16'h0000, 11'h000, 1'b1);
   endtask

   task automatic test_random();
      logic [15:0] expq [$];
      logic [15:0] exp_p, cur_a, cur_b;
      logic [10:0] cur_m;
      logic        have, ordy;
      int nin, nout;
      nin = 0; nout = 0; have = 1'b0;
      cur_a = 16'h0000; cur_b = 16'h0000; cur_m = 11'h000;
      for (int cyc = 0; cyc < 8000 && nout < 1000; cyc++) begin
         if (!have && nin < 1000) begin
            cur_a = {1'($urandom_range(0, 1)), 5'($urandom_range(1, 30)), 10'($urandom_range(0, 1023))};
            cur_b = {1'($urandom_range(0, 1)), 5'($urandom_range(1, 30)), 10'($urandom_range(0, 1023))};
            cur_m = 11'($urandom_range(0, 2047));
            have  = 1'b1;
         end
         ordy = ($urandom_range(0, 3) != 0);
         cycle(have, cur_a, cur_b, cur_m, ordy);
         if (obs_pop) begin
            total++;
            if (expq.size() == 0) begin
               bad++; $display("FAIL rand_extra: got %h want no result", obs_p);
            end else begin
               exp_p = expq.pop_front();
               if (obs_p !== exp_p) begin
                  bad++; $display("FAIL rand_p[%0d]: got %h want %h", nout, obs_p, exp_p);
               end
            end
            nout++;
         end
         if (obs_acc) begin
            expq.push_back(ref_mul(cur_a, cur_b, cur_m));
            nin++;
            have = 1'b0;
         end
      end
      total++;
      if (nout != 1000) begin
         bad++; $display("FAIL rand_count: got %0d want 1000", nout);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      bus.in_valid  = 1'b0;
      bus.a_i       = 16'h0000;
      bus.b_i       = 16'h0000;
      bus.mask_i    = 11'h000;
      bus.out_ready = 1'b0;
      init_tables();
      test_reset();
      test_directed();
      test_back_to_back();
      test_stall();
      test_reset_inflight();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
